ddr_axi_arbiter: RTL

Two-requester arbiter that shares the single AXI port of the DDR controller between two client blocks, e.g. Ethernet RX write-back and TX fetch. Each client issues single-burst read or write commands. The arbiter grants one command at a time, drives the AXI address channel, and steers write-data requests and read-data beats to the granted client. It replaces hard-wired DDR sequencing in the Ethernet test design.

---
 rtl/ddr_axi_arbiter_pkg.sv | 25 ++
 rtl/ddr_axi_arbiter_if.sv | 39 +++
 rtl/ddr_axi_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/ddr_axi_arbiter_pkg.sv
// ddr_arb_pkg: shared state encodings, widths and winner selection for ddr_axi_arbiter.
// DDR_ARB_FIXED_PRIO_EN switches winner selection from round-robin to fixed priority for port 0.
package ddr_arb_pkg;
  localparam int CTRL_ADDR_WIDTH = 28;
  localparam int MEM_DQ_WIDTH    = 32;
  localparam int AXI_DW          = MEM_DQ_WIDTH * 8;
  localparam int NUM_PORTS       = 2;
  typedef enum logic [4:0] {
    S_IDLE       = 5'b00001,
    S_WAIT_WA    = 5'b00010,
    S_WRITE_DATA = 5'b00100,
    S_WAIT_RA    = 5'b01000,
    S_READ_DATA  = 5'b10000
  } state_e;
`ifdef DDR_ARB_FIXED_PRIO_EN
  function automatic logic [NUM_PORTS-1:0] pick_winner(input logic [NUM_PORTS-1:0] v);
    return v[0] ? 2'b01 : v;
  endfunction
`else
  // On a tie the port that did not own the previous burst wins.
  function automatic logic [NUM_PORTS-1:0] pick_winner(input logic [NUM_PORTS-1:0] v, input logic last);
    return &v ? (last ? 2'b01 : 2'b10) : v;
  endfunction
`endif
endpackage

// File: rtl/ddr_axi_arbiter_if.sv
// ddr_axi_arbiter_if: client command/data ports plus the DDR controller AXI port.
interface ddr_axi_arbiter_if;
  import ddr_arb_pkg::*;
  logic                       p0_cmd_valid, p0_cmd_ready, p0_cmd_wr;
  logic [CTRL_ADDR_WIDTH-1:0] p0_cmd_addr;
  logic [3:0]                 p0_cmd_len;
  logic [AXI_DW-1:0]          p0_wr_data;
  logic                       p0_wr_req, p0_rd_valid, p0_rd_last;
  logic                       p1_cmd_valid, p1_cmd_ready, p1_cmd_wr;
  logic [CTRL_ADDR_WIDTH-1:0] p1_cmd_addr;
  logic [3:0]                 p1_cmd_len;
  logic [AXI_DW-1:0]          p1_wr_data;
  logic                       p1_wr_req, p1_rd_valid, p1_rd_last;
  logic [AXI_DW-1:0]          rd_data;
  logic [NUM_PORTS-1:0]       grant;
  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr, axi_araddr;
  logic [3:0]                 axi_awlen, axi_arlen;
  logic                       axi_awvalid, axi_awready, axi_arvalid, axi_arready;
  logic [AXI_DW-1:0]          axi_wdata, axi_rdata;
  logic                       axi_wready, axi_wusero_last, axi_rlast, axi_rvalid;
  modport master (
    input  p0_cmd_valid, p0_cmd_wr, p0_cmd_addr, p0_cmd_len, p0_wr_data,
    input  p1_cmd_valid, p1_cmd_wr, p1_cmd_addr, p1_cmd_len, p1_wr_data,
    output p0_cmd_ready, p0_wr_req, p0_rd_valid, p0_rd_last,
    output p1_cmd_ready, p1_wr_req, p1_rd_valid, p1_rd_last,
    output rd_data, grant,
    output axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_araddr, axi_arlen, axi_arvalid,
    input  axi_awready, axi_wready, axi_wusero_last, axi_arready, axi_rdata, axi_rlast, axi_rvalid
  );
  modport slave (
    output p0_cmd_valid, p0_cmd_wr, p0_cmd_addr, p0_cmd_len, p0_wr_data,
    output p1_cmd_valid, p1_cmd_wr, p1_cmd_addr, p1_cmd_len, p1_wr_data,
    input  p0_cmd_ready, p0_wr_req, p0_rd_valid, p0_rd_last,
    input  p1_cmd_ready, p1_wr_req, p1_rd_valid, p1_rd_last,
    input  rd_data, grant,
    input  axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_araddr, axi_arlen, axi_arvalid,
    output axi_awready, axi_wready, axi_wusero_last, axi_arready, axi_rdata, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/ddr_axi_arbiter.sv
// ddr_axi_arbiter: shares one DDR AXI port between two single-burst clients.
// DDR_ARB_FIXED_PRIO_EN: port 0 wins ties, and a simulation check compares beats against len+1.
module ddr_axi_arbiter
  import ddr_arb_pkg::*;
(
  input logic               core_clk,
  input logic               core_clk_rst_n,
  input logic               ddr_init_done,
  ddr_axi_arbiter_if.master bus
);
  state_e                     state_q;
  logic [NUM_PORTS-1:0]       grant_q, cmd_valid, pick;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q, cmd_addr;
  logic [3:0]                 len_q, cmd_len;
  logic                       awvalid_q, arvalid_q;
  logic                       accept, cmd_wr, wr_beat, rd_beat, wr_done, rd_done;
  assign cmd_valid = {bus.p1_cmd_valid, bus.p0_cmd_valid};
`ifdef DDR_ARB_FIXED_PRIO_EN
  assign pick = pick_winner(cmd_valid);
`else
  logic last_grant_q;
  assign pick = pick_winner(cmd_valid, last_grant_q);
`endif
  assign accept   = state_q == S_IDLE && ddr_init_done && |cmd_valid;
  assign cmd_wr   = pick[1] ? bus.p1_cmd_wr   : bus.p0_cmd_wr;
  assign cmd_addr = pick[1] ? bus.p1_cmd_addr : bus.p0_cmd_addr;
  assign cmd_len  = pick[1] ? bus.p1_cmd_len  : bus.p0_cmd_len;
  assign wr_beat  = state_q == S_WRITE_DATA && bus.axi_wready;
  assign rd_beat  = state_q == S_READ_DATA && bus.axi_rvalid;
  assign wr_done  = wr_beat && bus.axi_wusero_last;
  assign rd_done  = rd_beat && bus.axi_rlast;
  assign bus.p0_cmd_ready = accept && pick[0];
  assign bus.p1_cmd_ready = accept && pick[1];
  assign bus.p0_wr_req    = wr_beat && grant_q[0];
  assign bus.p1_wr_req    = wr_beat && grant_q[1];
  assign bus.p0_rd_valid  = rd_beat && grant_q[0];
  assign bus.p1_rd_valid  = rd_beat && grant_q[1];
  assign bus.p0_rd_last   = bus.p0_rd_valid && bus.axi_rlast;
  assign bus.p1_rd_last   = bus.p1_rd_valid && bus.axi_rlast;
  assign bus.axi_wdata    = grant_q[1] ? bus.p1_wr_data : bus.p0_wr_data;
  assign bus.rd_data      = bus.axi_rdata;
  assign bus.grant        = grant_q;
  assign bus.axi_awaddr   = addr_q;
  assign bus.axi_awlen    = len_q;
  assign bus.axi_awvalid  = awvalid_q;
  assign bus.axi_araddr   = addr_q;
  assign bus.axi_arlen    = len_q;
  assign bus.axi_arvalid  = arvalid_q;
  always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
    if (!core_clk_rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      addr_q       <= '0;
      len_q        <= 4'hf;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
`ifndef DDR_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          state_q   <= cmd_wr ? S_WAIT_WA : S_WAIT_RA;
          grant_q   <= pick;
          addr_q    <= cmd_addr;
          len_q     <= cmd_len;
          awvalid_q <= cmd_wr;
          arvalid_q <= !cmd_wr;
        end
        S_WAIT_WA: if (bus.axi_awready) begin
          state_q   <= S_WRITE_DATA;
          awvalid_q <= 1'b0;
        end
        S_WAIT_RA: if (bus.axi_arready) begin
          state_q   <= S_READ_DATA;
          arvalid_q <= 1'b0;
        end
        S_WRITE_DATA, S_READ_DATA: if (wr_done || rd_done) begin
          state_q      <= S_IDLE;
          grant_q      <= '0;
`ifndef DDR_ARB_FIXED_PRIO_EN
          last_grant_q <= grant_q[1];
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`ifdef DDR_ARB_FIXED_PRIO_EN
  logic [4:0] beat_cnt_q;
  always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
    if (!core_clk_rst_n) beat_cnt_q <= '0;
    else if (accept) beat_cnt_q <= '0;
    else if (wr_beat || rd_beat) beat_cnt_q <= beat_cnt_q + 5'd1;
  end
  // beat_cnt_q excludes the final beat, so a correct burst ends with beat_cnt_q == len.
  always_ff @(posedge core_clk) begin
    if (core_clk_rst_n && (wr_done || rd_done))
      assert (beat_cnt_q == {1'b0, len_q})
      else $error("ddr_axi_arbiter: burst ended after %0d beats, len %0d", beat_cnt_q + 5'd1, len_q);
  end
`endif
endmodule
